hex_display_scanner: RTL and testbench
======================================

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter CLK_RATE, default 100000000, input clock frequency in Hz.
REQ-002 Parameter REFRESH_RATE, default 10000, digit-advance rate in Hz; divisor DIV = CLK_RATE/REFRESH_RATE, integer, >= 2.
REQ-003 i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_rx_valid  input  1  byte-valid strobe from the UART receiver; one byte per cycle sampled high.
REQ-006 i_rx_byte  input  8  received byte; qualified by i_rx_valid.
REQ-007 i_clear  input  1  synchronous clear of captured history.
REQ-008 o_digit_nibble  output  4  hex value for the currently enabled digit, to the 7-segment decoder.
REQ-009 o_anodes  output  8  active-low digit enables; bit k drives digit k, with digit 0 rightmost.
REQ-010 o_rx_count  output  8  total bytes captured since reset/clear; wraps modulo 256.

Function
REQ-011 The tick counter SHALL count 0..DIV-1 and wrap to 0; a one-cycle internal tick SHALL be asserted when the count equals DIV-1.
REQ-012 On tick, digit index SHALL advance 0->1->...->7->0; it SHALL be held otherwise.
REQ-013 History SHALL be four 8-bit registers B0..B3, with B0 holding the newest byte.
REQ-014 On i_rx_valid=1 with i_clear=0, B3<=B2, B2<=B1, B1<=B0, B0<=i_rx_byte, and o_rx_count SHALL increment by 1 (255->0).
REQ-015 Fill count F (0..4) SHALL increment on each capture and saturate at 4.
REQ-016 Digit mapping: digit 2n SHALL show Bn[3:0] and digit 2n+1 SHALL show Bn[7:4], for n = 0..3.
REQ-017 Digits 2n and 2n+1 SHALL be blanked (all o_anodes bits high) while F <= n; o_digit_nibble SHALL then be 0.
REQ-018 o_anodes and o_digit_nibble SHALL be registered and change together.
REQ-019 Each cycle, o_anodes SHALL equal ~(1<<index) (or 8'hFF if blanked) and o_digit_nibble the mapped nibble, both computed from the index and history of the previous cycle, giving one cycle of latency.
REQ-020 Exactly one o_anodes bit SHALL be low at any time, or none when blanked.
REQ-021 i_clear=1 SHALL zero B0..B3, F and o_rx_count on the next edge.
REQ-022 i_clear SHALL win over a simultaneous i_rx_valid, and that byte SHALL be discarded.
REQ-023 i_clear SHALL NOT affect the tick counter or the digit index.
REQ-024 Capture and scanning SHALL be independent.
REQ-025 A capture coinciding with a tick SHALL apply both updates; the displayed nibble SHALL reflect new data from the following cycle.
REQ-026 No handshake back-pressure: every valid byte SHALL be accepted; a byte older than four captures is lost by design.

Reset
REQ-027 While i_rst_n=0: tick counter=0, index=0, B0..B3=0, F=0, o_rx_count=0, o_anodes=8'hFF, o_digit_nibble=4'h0.
REQ-028 Reset SHALL take effect immediately, without waiting for a clock edge, including mid-scan or mid-capture.
REQ-029 After deassertion, the first tick SHALL occur DIV cycles later.

Verification (CLK_RATE=1000, REFRESH_RATE=100, DIV=10)
REQ-030 Reset then idle 100 cycles -> o_anodes stays 8'hFF, o_digit_nibble=0, o_rx_count=0.
REQ-031 Single byte 8'hA5, then scan 80 cycles -> digit 0 enabled (o_anodes=8'hFE) with nibble 5; digit 1 (8'hFD) with nibble A; digits 2-7 blanked.
REQ-032 Bytes 12,34,56,78,9A on consecutive cycles -> o_rx_count=5; full scan shows digits 0..7 = A,9,8,7,6,5,4,3; byte 12 gone.
REQ-033 i_clear and i_rx_valid (8'hFF) in the same cycle -> o_rx_count=0, all digits blanked, index continues its sequence uninterrupted.
REQ-034 256 captures -> o_rx_count wraps to 0 while F stays 4 and all eight digits remain enabled in rotation.
REQ-035 Assert i_rst_n low asynchronously mid-tick with index=5 -> o_anodes=8'hFF before the next edge; after release, index restarts at 0 and the first tick occurs after 10 cycles.

Source files
------------

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - scans the last four received bytes across eight multiplexed hex digits
module hex_display_scanner #(
    parameter int CLK_RATE     = 100000000,
    parameter int REFRESH_RATE = 10000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    input  logic       i_clear,
    output logic [3:0] o_digit_nibble,
    output logic [7:0] o_anodes,
    output logic [7:0] o_rx_count
);
    localparam int DIV = CLK_RATE / REFRESH_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [2:0]      digit_idx;
    logic [3:0][7:0] hist;
    logic [2:0]      fill;

    logic [7:0] sel_byte;
    logic [3:0] sel_nibble;
    logic       blank;
    logic [7:0] next_anodes;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt  <= '0;
            digit_idx <= 3'd0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            if (tick)
                digit_idx <= digit_idx + 3'd1;
        end
    end

    // History shifts newest-first; clear takes priority and drops a simultaneous byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist       <= '0;
            fill       <= 3'd0;
            o_rx_count <= 8'd0;
        end else if (i_clear) begin
            hist       <= '0;
            fill       <= 3'd0;
            o_rx_count <= 8'd0;
        end else if (i_rx_valid) begin
            hist       <= {hist[2:0], i_rx_byte};
            fill       <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
            o_rx_count <= o_rx_count + 8'd1;
        end
    end

    // Digit pair n shows byte n; the pair is dark until at least n+1 bytes have arrived.
    always_comb begin
        sel_byte    = hist[digit_idx[2:1]];
        sel_nibble  = digit_idx[0] ? sel_byte[7:4] : sel_byte[3:0];
        blank       = (fill <= {1'b0, digit_idx[2:1]});
        next_anodes = blank ? 8'hFF : ~(8'd1 << digit_idx);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_anodes       <= 8'hFF;
            o_digit_nibble <= 4'h0;
        end else begin
            o_anodes       <= next_anodes;
            o_digit_nibble <= blank ? 4'h0 : sel_nibble;
        end
    end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - self-checking bench for hex_display_scanner against a queue-based model
module tb_hex_display_scanner;
    localparam int CLK_RATE     = 1000;
    localparam int REFRESH_RATE = 100;
    localparam int DIV          = CLK_RATE / REFRESH_RATE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       clear = 1'b0;
    logic [3:0] digit_nibble;
    logic [7:0] anodes;
    logic [7:0] rx_count;

    hex_display_scanner #(.CLK_RATE(CLK_RATE), .REFRESH_RATE(REFRESH_RATE)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_valid     (rx_valid),
        .i_rx_byte      (rx_byte),
        .i_clear        (clear),
        .o_digit_nibble (digit_nibble),
        .o_anodes       (anodes),
        .o_rx_count     (rx_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: edges since reset release, newest-first byte queue, capture total.
    int         k = 0;
    logic [7:0] hist[$];
    int         cnt = 0;

    logic [3:0] seen_nib[8];
    logic       seen[8];

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       c;
        int         exp_count;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_outputs(output logic [7:0] an, output logic [3:0] nib);
        int idx;
        int n;
        logic [7:0] b;
        idx = (k / DIV) % 8;
        n   = idx / 2;
        if (hist.size() <= n) begin
            an  = 8'hFF;
            nib = 4'h0;
        end else begin
            an  = ~(8'd1 << idx);
            b   = hist[n];
            nib = (idx % 2 == 1) ? b[7:4] : b[3:0];
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] b, input logic c);
        logic [7:0] ea;
        logic [3:0] en;
        rx_valid = v;
        rx_byte  = b;
        clear    = c;
        model_outputs(ea, en);
        if (c) begin
            hist.delete();
            cnt = 0;
        end else if (v) begin
            hist.push_front(b);
            if (hist.size() > 4) void'(hist.pop_back());
            cnt = (cnt + 1) % 256;
        end
        k++;
        @(posedge clk);
        @(negedge clk);
        check("anodes", anodes, ea);
        check("nibble", digit_nibble, en);
        check("rx_count", rx_count, cnt);
    endtask

    task automatic scan(input int n);
        logic [7:0] m;
        for (int d = 0; d < 8; d++) begin
            seen[d]     = 1'b0;
            seen_nib[d] = 4'h0;
        end
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            check("onehot_or_none", int'($countones(~anodes) <= 1), 1);
            for (int d = 0; d < 8; d++) begin
                m = 8'd1 << d;
                if (anodes == ~m) begin
                    seen[d]     = 1'b1;
                    seen_nib[d] = digit_nibble;
                end
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        hist.delete();
        cnt   = 0;
    endtask

    initial begin
        logic [3:0] exp_digits[8];
        int guard;
        exp_digits = '{4'hA, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3};
        vecs[0] = '{1'b0, 8'h00, 1'b1, 0};
        vecs[1] = '{1'b1, 8'h12, 1'b0, 1};
        vecs[2] = '{1'b1, 8'h34, 1'b0, 2};
        vecs[3] = '{1'b1, 8'h56, 1'b0, 3};
        vecs[4] = '{1'b1, 8'h78, 1'b0, 4};
        vecs[5] = '{1'b1, 8'h9A, 1'b0, 5};

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_anodes", anodes, 8'hFF);
        check("rst_nibble", digit_nibble, 0);
        check("rst_count", rx_count, 0);
        release_reset();

        // Idle: everything blank
        repeat (100) cycle(1'b0, 8'h00, 1'b0);
        check("idle_anodes", anodes, 8'hFF);

        // Single byte A5
        cycle(1'b1, 8'hA5, 1'b0);
        scan(80);
        check("a5_d0_seen", seen[0], 1);
        check("a5_d0_nib", seen_nib[0], 4'h5);
        check("a5_d1_seen", seen[1], 1);
        check("a5_d1_nib", seen_nib[1], 4'hA);
        for (int d = 2; d < 8; d++) check("a5_blank", seen[d], 0);

        // Five consecutive bytes, oldest drops off
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].v, vecs[i].b, vecs[i].c);
            check("vec_count", rx_count, vecs[i].exp_count);
        end
        scan(80);
        for (int d = 0; d < 8; d++) begin
            check("full_seen", seen[d], 1);
            check("full_digit", seen_nib[d], exp_digits[d]);
        end

        // Clear wins over a simultaneous capture
        cycle(1'b1, 8'hFF, 1'b1);
        check("clear_count", rx_count, 0);
        scan(80);
        for (int d = 0; d < 8; d++) check("clear_blank", seen[d], 0);

        // 256 captures wrap the counter while all digits stay lit
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'($urandom), 1'b0);
        check("wrap_count", rx_count, 0);
        scan(80);
        for (int d = 0; d < 8; d++) check("wrap_seen", seen[d], 1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 40) == 0));

        // Async reset mid-scan at index 5
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
        guard = 0;
        while (!(((k / DIV) % 8 == 5) && (k % DIV == 4)) && guard < 200) begin
            cycle(1'b0, 8'h00, 1'b0);
            guard++;
        end
        check("reach_idx5", int'(guard < 200), 1);
        check("pre_rst_anodes", anodes, 8'hDF);
        #2;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        clear    = 1'b0;
        #1;
        check("async_anodes", anodes, 8'hFF);
        check("async_nibble", digit_nibble, 0);
        check("async_count", rx_count, 0);
        release_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0);
        // Edge 10 after release is the first tick; digit 1 appears one edge later
        repeat (6) cycle(1'b0, 8'h00, 1'b0);
        check("pre_tick_anodes", anodes, 8'hFE);
        cycle(1'b0, 8'h00, 1'b0);
        check("post_tick_anodes", anodes, 8'hFD);
        repeat (40) cycle(1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
